// File: rtl/program_counter.sv
// Program-counter register for the instruction-fetch stage.
// Loads the upstream next-PC each cycle unless halted; async active-low reset to RESET_ADDR.
module program_counter #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic [WIDTH-1:0] address_in,
  output logic [WIDTH-1:0] address_out,
  input  logic             halt,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Priority below reset: halt holds, otherwise load address_in verbatim.
  always_comb begin
    pc_d = pc_q;
    if (!halt) begin
      pc_d = address_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign address_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: vector table plus hand-written reset sequences,
// with a second instance using a non-zero reset vector.
module tb_program_counter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         halt;
  logic [W-1:0] address_in;
  logic [W-1:0] address_out;
  logic [W-1:0] address_out_rv;

  always #10 clk = ~clk;

  program_counter #(.WIDTH(W), .RESET_ADDR(16'h0000)) u_dut (
    .address_in  (address_in),
    .address_out (address_out),
    .halt        (halt),
    .clk         (clk),
    .reset       (reset)
  );

  program_counter #(.WIDTH(W), .RESET_ADDR(16'h0100)) u_dut_rv (
    .address_in  (address_in),
    .address_out (address_out_rv),
    .halt        (halt),
    .clk         (clk),
    .reset       (reset)
  );

  typedef struct {
    logic         halt;
    logic [W-1:0] addr;
    logic [W-1:0] exp;
    logic [W-1:0] exp_rv;
    string        name;
  } vec_t;

  localparam int N_VEC = 14;
  vec_t vecs [N_VEC];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rv_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic set_vec(input int i, input logic h, input logic [W-1:0] a,
                         input logic [W-1:0] e, input logic [W-1:0] erv, input string nm);
    vecs[i].halt   = h;
    vecs[i].addr   = a;
    vecs[i].exp    = e;
    vecs[i].exp_rv = erv;
    vecs[i].name   = nm;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: address_out=%h required=%h", name, act, exp);
    end
  endtask

  // Pop both expected values and compare against the two instances.
  task automatic compare_outputs(input string name);
    if (exp_q.size() == 0 || exp_rv_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, address_out, exp_q.pop_front());
      check({name, "_rv"}, address_out_rv, exp_rv_q.pop_front());
    end
  endtask

  task automatic push_exp(input logic [W-1:0] e, input logic [W-1:0] erv);
    exp_q.push_back(e);
    exp_rv_q.push_back(erv);
  endtask

  task automatic run_vec(input int i);
    halt       = vecs[i].halt;
    address_in = vecs[i].addr;
    push_exp(vecs[i].exp, vecs[i].exp_rv);
    @(posedge clk);
    #1;
    compare_outputs(vecs[i].name);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0,  1'b0, 16'h0000, 16'h0000, 16'h0000, "load0");
    set_vec(1,  1'b0, 16'h0002, 16'h0002, 16'h0002, "load2");
    set_vec(2,  1'b0, 16'h0004, 16'h0004, 16'h0004, "load4");
    set_vec(3,  1'b0, 16'h0000, 16'h0000, 16'h0000, "rel_load0");
    set_vec(4,  1'b0, 16'h0002, 16'h0002, 16'h0002, "rel_load2");
    set_vec(5,  1'b1, 16'h0002, 16'h0002, 16'h0002, "halt_a2");
    set_vec(6,  1'b1, 16'h0008, 16'h0002, 16'h0002, "halt_a8");
    set_vec(7,  1'b1, 16'hABCD, 16'h0002, 16'h0002, "halt_abcd");
    set_vec(8,  1'b0, 16'h0008, 16'h0008, 16'h0008, "resume8");
    set_vec(9,  1'b0, 16'h1234, 16'h1234, 16'h1234, "load1234");
    set_vec(10, 1'b1, 16'h5555, 16'h0000, 16'h0100, "halt_after_rel0");
    set_vec(11, 1'b1, 16'h5555, 16'h0000, 16'h0100, "halt_after_rel1");
    set_vec(12, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, "load_ffff");
    set_vec(13, 1'b0, 16'h0001, 16'h0001, 16'h0001, "load_odd1");

    reset      = 1'b1;
    halt       = 1'b0;
    address_in = '0;

    for (int i = 0; i < 3; i++) run_vec(i);

    // Asynchronous assertion mid-cycle: output must change before any clock edge.
    address_in = 16'h0006;
    #5 reset = 1'b0;
    #1;
    push_exp(16'h0000, 16'h0100);
    compare_outputs("async_rst");
    @(posedge clk);
    #1;
    push_exp(16'h0000, 16'h0100);
    compare_outputs("rst_hold_edge");
    @(negedge clk);
    reset = 1'b1;
    #1;
    push_exp(16'h0000, 16'h0100);
    compare_outputs("rst_release_no_change");

    for (int i = 3; i < 10; i++) run_vec(i);

    // Reset must win over halt, and release with halt high keeps the reset vector.
    halt = 1'b1;
    #5 reset = 1'b0;
    #1;
    push_exp(16'h0000, 16'h0100);
    compare_outputs("rst_over_halt");
    @(posedge clk);
    #1;
    push_exp(16'h0000, 16'h0100);
    compare_outputs("rst_over_halt_edge");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 10; i < N_VEC; i++) run_vec(i);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
